pcu_fetch: RTL and testbench
============================

// Module: pcu_fetch
// PURPOSE
//   Parametrised PC unit and fetch controller for the pipelined core; successor of the single-cycle PC register.
//   Holds the fetch PC, issues instruction reads over a valid/ready request channel, and accepts one response per request.
//   Buffers the fetched instruction in a 1-entry output slot for decode.
//   Redirects (ecall, mret, EX branch/jump) kill any in-flight fetch.
// PARAMETERS
//   XLEN      64            PC/address width
//   ILEN      32            instruction width
//   RESET_PC  64'h8000_0000 first fetch address after reset
//   PC_STEP   4             sequential increment; 4 or 2 (compressed); target LSBs force-aligned to it
// PORTS
//   i_clk       in   1     clock, rising edge
//   i_rst_n     in   1     asynchronous active-low reset
//   i_ecall     in   1     trap taken; target i_mtvec
//   i_mret      in   1     trap return; target i_mepc
//   i_mtvec     in   XLEN  trap vector
//   i_mepc      in   XLEN  exception return PC
//   i_redir     in   1     branch taken / jal / jalr resolved in EX
//   i_redir_pc  in   XLEN  redirect target (pc+imm or rs1+imm, computed upstream)
//   o_req_vld   out  1     fetch request valid
//   o_req_addr  out  XLEN  fetch address
//   i_req_rdy   in   1     memory accepts request
//   i_rsp_vld   in   1     fetch response valid (exactly one per accepted request)
//   i_rsp_inst  in   ILEN  fetched instruction
//   o_if_vld    out  1     output slot holds a valid instruction
//   o_if_pc     out  XLEN  PC of o_if_inst
//   o_if_inst   out  ILEN  instruction to decode
//   i_if_rdy    in   1     decode consumes slot when o_if_vld && i_if_rdy
// BEHAVIOUR
//   Reset: state=S_IDLE, pc_r=RESET_PC, kill=0, o_req_vld=0, o_if_vld=0, o_if_pc=0, o_if_inst=0.
//   FSM states S_IDLE, S_REQ, S_WAIT, S_HOLD; S_IDLE -> S_REQ unconditionally on the first clock after reset release.
//   S_REQ: o_req_vld=1, o_req_addr=pc_r. On i_req_rdy: fly_pc<=pc_r, pc_r<=pc_r+PC_STEP, -> S_WAIT.
//   While o_req_vld && !i_req_rdy, o_req_vld and o_req_addr stay stable, even across a redirect.
//   S_WAIT: on i_rsp_vld:
//     - kill=1: drop response, kill<=0, -> S_REQ.
//     - else: slot<={fly_pc, i_rsp_inst}, o_if_vld<=1, -> S_HOLD.
//   S_HOLD: when o_if_vld && i_if_rdy, o_if_vld<=0 and -> S_REQ (request in next cycle); else hold.
//   i_rsp_vld is ignored in S_IDLE/S_REQ/S_HOLD.
//   Redirect priority: i_ecall > i_mret > i_redir; target = i_mtvec / i_mepc / i_redir_pc, LSBs cleared to PC_STEP alignment.
//   Redirect effect at the same edge (overrides all other updates of the same cycle):
//     - pc_r<=target, o_if_vld<=0 (slot flushed, i_if_rdy ignored).
//     - S_REQ with i_req_rdy=1: request is stale; kill<=1, -> S_WAIT, pc_r=target (not target+step).
//     - S_REQ with i_req_rdy=0: kill<=1, stay S_REQ; old address keeps being requested until accepted, then S_WAIT drops its response.
//     - S_WAIT without i_rsp_vld: kill<=1. With i_rsp_vld the same cycle: response dropped, -> S_REQ.
//     - S_HOLD: -> S_REQ. S_IDLE: pc_r<=target only.
//   Redirect again while kill=1 updates pc_r only; at most one outstanding request, so one kill bit suffices.
//   Latency: redirect at edge N -> new target on o_req_addr from cycle N+1, or after the stale request handshakes and its response returns.
//   Throughput: request issues once the slot is empty; no back-to-back overlap (one outstanding request).
//   Arithmetic: pc_r+PC_STEP wraps modulo 2^XLEN (e.g. all-ones-aligned -> 0), no overflow flag.
//   Async reset mid-operation: all state returns to reset values immediately; late responses land in S_IDLE/S_REQ and are ignored.
// TESTING
//   1. Reset release, i_req_rdy=1, response 1 cycle later -> addrs 0x80000000, 0x80000004, 0x80000008; o_if_pc matches each inst.
//   2. i_req_rdy low 3 cycles -> o_req_vld/o_req_addr 0x80000000 stable all 3; one handshake only.
//   3. i_redir=1, i_redir_pc=0x80001002 in S_WAIT -> response dropped, o_if_vld stays 0; next o_req_addr=0x80001000.
//   4. i_ecall+i_mret+i_redir same cycle, i_mtvec=0x80000100 -> next o_req_addr=0x80000100.
//   5. o_if_vld=1, i_if_rdy=0 for 4 cycles -> slot pc/inst held, o_req_vld=0; i_mret with i_mepc=0x80000040 -> o_if_vld=0, refetch 0x80000040.
//   6. pc_r=XLEN'hFFFF_FFFF_FFFF_FFFC handshakes -> following o_req_addr=0; i_rst_n low while in S_WAIT -> outputs reset, late i_rsp_vld ignored.

Source files
------------

// File: rtl/pcu_fetch_if.sv
// Fetch-side bus of the PC unit: instruction request/response channel and decode output slot.
// Signal names carry the direction as seen from the fetch unit (master).
interface pcu_fetch_if #(
    parameter int unsigned XLEN = 64,
    parameter int unsigned ILEN = 32
);
    logic            o_req_vld;
    logic [XLEN-1:0] o_req_addr;
    logic            i_req_rdy;
    logic            i_rsp_vld;
    logic [ILEN-1:0] i_rsp_inst;
    logic            o_if_vld;
    logic [XLEN-1:0] o_if_pc;
    logic [ILEN-1:0] o_if_inst;
    logic            i_if_rdy;

    modport master (
        output o_req_vld, o_req_addr, o_if_vld, o_if_pc, o_if_inst,
        input  i_req_rdy, i_rsp_vld, i_rsp_inst, i_if_rdy
    );

    modport slave (
        input  o_req_vld, o_req_addr, o_if_vld, o_if_pc, o_if_inst,
        output i_req_rdy, i_rsp_vld, i_rsp_inst, i_if_rdy
    );
endinterface

// File: rtl/pcu_fetch.sv
// PC unit and fetch controller: one outstanding instruction request, 1-entry decode slot,
// redirects (ecall > mret > EX redirect) kill any in-flight fetch via a single kill bit.
module pcu_fetch #(
    parameter int unsigned     XLEN     = 64,
    parameter int unsigned     ILEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(64'h8000_0000),
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_ecall,
    input  logic            i_mret,
    input  logic [XLEN-1:0] i_mtvec,
    input  logic [XLEN-1:0] i_mepc,
    input  logic            i_redir,
    input  logic [XLEN-1:0] i_redir_pc,
    pcu_fetch_if.master     io_fetch
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_e;

    localparam logic [XLEN-1:0] STEP       = XLEN'(PC_STEP);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~(STEP - XLEN'(1));

    state_e          r_state, w_state_nxt;
    logic [XLEN-1:0] r_pc, w_pc_nxt;
    logic [XLEN-1:0] r_fly_pc, w_fly_pc_nxt;
    logic            r_kill, w_kill_nxt;
    logic            r_if_vld, w_if_vld_nxt;
    logic [XLEN-1:0] r_if_pc, w_if_pc_nxt;
    logic [ILEN-1:0] r_if_inst, w_if_inst_nxt;
    logic            w_redir;
    logic [XLEN-1:0] w_target;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_fly_pc  <= '0;
            r_kill    <= 1'b0;
            r_if_vld  <= 1'b0;
            r_if_pc   <= '0;
            r_if_inst <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_fly_pc  <= w_fly_pc_nxt;
            r_kill    <= w_kill_nxt;
            r_if_vld  <= w_if_vld_nxt;
            r_if_pc   <= w_if_pc_nxt;
            r_if_inst <= w_if_inst_nxt;
        end
    end

    always_comb begin
        w_redir       = i_ecall | i_mret | i_redir;
        w_target      = (i_ecall ? i_mtvec : (i_mret ? i_mepc : i_redir_pc)) & ALIGN_MASK;
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_fly_pc_nxt  = r_fly_pc;
        w_kill_nxt    = r_kill;
        w_if_vld_nxt  = r_if_vld;
        w_if_pc_nxt   = r_if_pc;
        w_if_inst_nxt = r_if_inst;

        unique case (r_state)
            S_IDLE: w_state_nxt = S_REQ;
            S_REQ: begin
                // While killed, r_fly_pc holds the stale address still being offered.
                if (!r_kill) w_fly_pc_nxt = r_pc;
                if (io_fetch.i_req_rdy) begin
                    w_state_nxt = S_WAIT;
                    if (!r_kill) w_pc_nxt = r_pc + STEP;
                end
                if (w_redir) w_kill_nxt = 1'b1;
            end
            S_WAIT: begin
                if (io_fetch.i_rsp_vld) begin
                    w_kill_nxt  = 1'b0;
                    w_state_nxt = S_REQ;
                    if (!r_kill && !w_redir) begin
                        w_if_vld_nxt  = 1'b1;
                        w_if_pc_nxt   = r_fly_pc;
                        w_if_inst_nxt = io_fetch.i_rsp_inst;
                        w_state_nxt   = S_HOLD;
                    end
                end else if (w_redir) begin
                    w_kill_nxt = 1'b1;
                end
            end
            S_HOLD: begin
                if ((r_if_vld && io_fetch.i_if_rdy) || w_redir) begin
                    w_if_vld_nxt = 1'b0;
                    w_state_nxt  = S_REQ;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // A redirect overrides every other PC/slot update of the cycle.
        if (w_redir) begin
            w_pc_nxt     = w_target;
            w_if_vld_nxt = 1'b0;
        end
    end

    assign io_fetch.o_req_vld  = (r_state == S_REQ);
    assign io_fetch.o_req_addr = r_kill ? r_fly_pc : r_pc;
    assign io_fetch.o_if_vld   = r_if_vld;
    assign io_fetch.o_if_pc    = r_if_pc;
    assign io_fetch.o_if_inst  = r_if_inst;
endmodule

// File: tb/tb_pcu_fetch.sv
// Bench for pcu_fetch: directed scenarios then randomized traffic, checked every cycle
// against a transaction-level model of the fetch unit.
module tb_pcu_fetch;
    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;
    localparam int unsigned STEP = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            ecall, mret, redir;
    logic [XLEN-1:0] mtvec, mepc, redir_pc;

    always #5 clk = ~clk;

    pcu_fetch_if #(.XLEN(XLEN), .ILEN(ILEN)) u_if ();

    pcu_fetch #(
        .XLEN(XLEN), .ILEN(ILEN), .RESET_PC(64'h8000_0000), .PC_STEP(STEP)
    ) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ecall(ecall), .i_mret(mret), .i_mtvec(mtvec),
        .i_mepc(mepc), .i_redir(redir), .i_redir_pc(redir_pc), .io_fetch(u_if.master)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Model: next fetch pc, request on offer, outstanding request, drop flag, decode slot.
    logic [63:0] m_pc, m_stale, m_out_pc, m_slot_pc;
    logic [31:0] m_slot_inst;
    bit          m_started, m_offer, m_out, m_drop, m_slot_vld, m_hs;
    // Memory responder.
    bit          mem_pend;
    int          mem_lat, lat_lo, lat_hi;
    logic [31:0] mem_inst;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_pc = 64'h8000_0000; m_stale = '0; m_out_pc = '0; m_slot_pc = '0; m_slot_inst = '0;
        m_started = 0; m_offer = 0; m_out = 0; m_drop = 0; m_slot_vld = 0; m_hs = 0;
    endtask

    task automatic model_step();
        bit rd, hs, rsp, cons, offer0, out0, slot0;
        logic [63:0] tgt, pc0;
        m_hs = 0;
        if (!rst_n) return;
        rd  = ecall | mret | redir;
        tgt = (ecall ? mtvec : (mret ? mepc : redir_pc)) & ~64'(STEP - 1);
        if (!m_started) begin
            m_started = 1; m_offer = 1;
            if (rd) m_pc = tgt;
            return;
        end
        offer0 = m_offer; out0 = m_out; slot0 = m_slot_vld; pc0 = m_pc;
        hs   = m_offer && u_if.i_req_rdy;
        rsp  = m_out && u_if.i_rsp_vld;
        cons = m_slot_vld && u_if.i_if_rdy;
        m_hs = hs;
        if (hs) begin
            m_offer = 0; m_out = 1;
            if (!m_drop) begin m_out_pc = m_pc; m_pc = m_pc + 64'(STEP); end
        end
        if (rsp) begin
            m_out = 0;
            if (m_drop || rd) begin
                m_drop = 0; m_offer = 1;
            end else begin
                m_slot_vld = 1; m_slot_pc = m_out_pc; m_slot_inst = u_if.i_rsp_inst;
            end
        end
        if (cons && !rd) begin m_slot_vld = 0; m_offer = 1; end
        if (rd) begin
            m_pc = tgt;
            if (slot0) begin m_slot_vld = 0; m_offer = 1; end
            if (offer0 && !hs && !m_drop) m_stale = pc0;
            if ((offer0 && !hs) || hs || (out0 && !rsp)) m_drop = 1;
        end
    endtask

    task automatic drive_mem();
        u_if.i_rsp_vld  = mem_pend && (mem_lat == 0);
        u_if.i_rsp_inst = (mem_pend && (mem_lat == 0)) ? mem_inst : 32'($urandom);
    endtask

    task automatic mem_update();
        if (u_if.i_rsp_vld) mem_pend = 0;
        else if (mem_pend) mem_lat--;
        if (m_hs) begin
            mem_pend = 1;
            mem_lat  = $urandom_range(lat_hi, lat_lo);
            mem_inst = $urandom;
        end
    endtask

    task automatic compare();
        chk("req_vld", 64'(u_if.o_req_vld), 64'(m_offer));
        if (m_offer) chk("req_addr", u_if.o_req_addr, m_drop ? m_stale : m_pc);
        chk("if_vld", 64'(u_if.o_if_vld), 64'(m_slot_vld));
        if (m_slot_vld) begin
            chk("if_pc", u_if.o_if_pc, m_slot_pc);
            chk("if_inst", 64'(u_if.o_if_inst), 64'(m_slot_inst));
        end
    endtask

    task automatic tick();
        drive_mem();
        @(posedge clk);
        model_step();
        mem_update();
        #1;
        compare();
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (!u_if.o_req_vld && n < 20) begin tick(); n++; end
        chk({tag, "_req_seen"}, 64'(u_if.o_req_vld), 64'd1);
    endtask

    task automatic wait_if(input string tag);
        int n = 0;
        while (!u_if.o_if_vld && n < 20) begin tick(); n++; end
        chk({tag, "_if_seen"}, 64'(u_if.o_if_vld), 64'd1);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_req_vld"}, 64'(u_if.o_req_vld), 64'd0);
        chk({tag, "_if_vld"}, 64'(u_if.o_if_vld), 64'd0);
        chk({tag, "_if_pc"}, u_if.o_if_pc, 64'd0);
        chk({tag, "_if_inst"}, 64'(u_if.o_if_inst), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        ecall = 0; mret = 0; redir = 0; mtvec = '0; mepc = '0; redir_pc = '0;
        u_if.i_req_rdy = 0; u_if.i_rsp_vld = 0; u_if.i_rsp_inst = '0; u_if.i_if_rdy = 0;
        lat_lo = 0; lat_hi = 0; mem_pend = 0; mem_lat = 0; mem_inst = '0;
        model_reset();
        #12;
        chk_reset_outs("rst");
        tick(); tick();
        rst_n = 1'b1;

        // Sequential fetch with a one-cycle memory.
        u_if.i_req_rdy = 1; u_if.i_if_rdy = 1;
        for (int k = 0; k < 3; k++) begin
            wait_req("t1");
            chk("t1_addr", u_if.o_req_addr, 64'h8000_0000 + 64'(4 * k));
            wait_if("t1");
            chk("t1_if_pc", u_if.o_if_pc, 64'h8000_0000 + 64'(4 * k));
        end

        // Stalled request stays stable, single handshake.
        rst_n = 1'b0; model_reset(); tick(); rst_n = 1'b1;
        u_if.i_req_rdy = 0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t2_vld", 64'(u_if.o_req_vld), 64'd1);
            chk("t2_addr", u_if.o_req_addr, 64'h8000_0000);
            tick();
        end
        lat_lo = 2; lat_hi = 2;
        u_if.i_req_rdy = 1;
        tick();
        chk("t2_single_hs", 64'(u_if.o_req_vld), 64'd0);

        // Redirect while waiting: response dropped, misaligned target aligned.
        redir = 1; redir_pc = 64'h8000_1002;
        tick();
        redir = 0;
        begin
            int n = 0;
            while (!u_if.o_req_vld && n < 10) begin
                chk("t3_no_slot", 64'(u_if.o_if_vld), 64'd0);
                tick(); n++;
            end
        end
        chk("t3_req_seen", 64'(u_if.o_req_vld), 64'd1);
        chk("t3_addr", u_if.o_req_addr, 64'h8000_1000);
        lat_lo = 0; lat_hi = 0;

        // Simultaneous ecall/mret/redir: ecall wins.
        wait_if("t4");
        ecall = 1; mret = 1; redir = 1;
        mtvec = 64'h8000_0100; mepc = 64'h8000_2000; redir_pc = 64'h8000_3000;
        tick();
        ecall = 0; mret = 0; redir = 0;
        chk("t4_flush", 64'(u_if.o_if_vld), 64'd0);
        wait_req("t4");
        chk("t4_addr", u_if.o_req_addr, 64'h8000_0100);

        // Slot held under back-pressure, then flushed by mret.
        u_if.i_if_rdy = 0;
        wait_if("t5");
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_hold_vld", 64'(u_if.o_if_vld), 64'd1);
            chk("t5_hold_pc", u_if.o_if_pc, 64'h8000_0100);
            chk("t5_no_req", 64'(u_if.o_req_vld), 64'd0);
        end
        mret = 1; mepc = 64'h8000_0040;
        tick();
        mret = 0;
        chk("t5_flush", 64'(u_if.o_if_vld), 64'd0);
        wait_req("t5");
        chk("t5_addr", u_if.o_req_addr, 64'h8000_0040);
        u_if.i_if_rdy = 1;

        // PC wrap to zero, then async reset with a late response.
        redir = 1; redir_pc = 64'hFFFF_FFFF_FFFF_FFFE;
        tick();
        redir = 0;
        wait_req("t6a");
        chk("t6_top_addr", u_if.o_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        wait_if("t6");
        chk("t6_top_pc", u_if.o_if_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        wait_req("t6b");
        chk("t6_wrap_addr", u_if.o_req_addr, 64'd0);
        lat_lo = 1; lat_hi = 1;
        tick();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk_reset_outs("t6_async");
        compare();
        tick();
        rst_n = 1'b1;
        tick();
        chk("t6_late_ignored", 64'(u_if.o_if_vld), 64'd0);
        chk("t6_restart_addr", u_if.o_req_addr, 64'h8000_0000);

        // Randomized traffic.
        lat_lo = 0; lat_hi = 3;
        for (int c = 0; c < 800; c++) begin
            int r;
            u_if.i_req_rdy = ($urandom % 4) != 0;
            u_if.i_if_rdy  = ($urandom % 3) != 0;
            r = $urandom % 16;
            ecall = (r == 0); mret = (r == 1); redir = (r == 2) || (r == 3);
            mtvec = {$urandom, $urandom}; mepc = {$urandom, $urandom};
            redir_pc = {$urandom, $urandom};
            if (($urandom % 250) == 0) begin
                rst_n = 1'b0; model_reset(); tick(); rst_n = 1'b1;
            end
            tick();
        end
        ecall = 0; mret = 0; redir = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
